// File: rtl/shift_buffer_ctrl_if.sv
// rtl/shift_buffer_ctrl_if.sv - column fetch, shift-buffer strobe and output handshake bundle
interface shift_buffer_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              sb_write_en;
  logic              sb_read_en;
  logic              out_ready;
  logic              out_valid;
  logic              out_last;

  modport master (
    output mem_rd_en, mem_addr, sb_write_en, sb_read_en, out_valid, out_last,
    input  mem_ack, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, sb_write_en, sb_read_en, out_valid, out_last,
    output mem_ack, out_ready
  );
endinterface

// File: rtl/shift_buffer_ctrl.sv
// rtl/shift_buffer_ctrl.sv - 4x4 sliding-window shift buffer sequencer
// Optional abort input enabled by SBC_ABORT_EN.
module shift_buffer_ctrl #(
  parameter int COLS   = 8,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef SBC_ABORT_EN
  input  logic abort,
`endif
  output logic busy,
  output logic done,
  shift_buffer_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READ, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [2:0]        loaded_q, loaded_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              wr_en, rd_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      loaded_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      loaded_q    <= loaded_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    loaded_d = loaded_q;
    rd_cnt_d = rd_cnt_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          col_d    = '0;
          loaded_d = '0;
        end
      end
      S_FETCH: begin
        if (bus.mem_ack) begin
          wr_en    = 1'b1;
          loaded_d = (loaded_q == 3'd4) ? 3'd4 : loaded_q + 3'd1;
          // Only the first window needs four columns; later windows slide by one.
          if (loaded_q < 3'd3) begin
            col_d = col_q + ADDR_W'(1);
          end else begin
            state_d  = S_READ;
            rd_cnt_d = '0;
          end
        end
      end
      S_READ: begin
        if (bus.out_ready) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + 4'd1;
          if (rd_cnt_q == 4'd15) begin
            if (col_q == LAST_COL) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FETCH;
              col_d   = col_q + ADDR_W'(1);
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef SBC_ABORT_EN
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      col_d    = '0;
      loaded_d = '0;
      rd_cnt_d = '0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
    end
`endif
    out_valid_d = rd_en;
    out_last_d  = rd_en && (rd_cnt_q == 4'd15);
  end

  assign busy            = (state_q != S_IDLE);
`ifdef SBC_ABORT_EN
  assign done            = (state_q == S_DONE) && !abort;
`else
  assign done            = (state_q == S_DONE);
`endif
  assign bus.mem_rd_en   = (state_q == S_FETCH);
  assign bus.mem_addr    = (state_q == S_FETCH) ? col_q : '0;
  assign bus.sb_write_en = wr_en;
  assign bus.sb_read_en  = rd_en;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;

endmodule

// File: tb/tb_shift_buffer_ctrl.sv
// tb/tb_shift_buffer_ctrl.sv - directed bench for shift_buffer_ctrl
module tb_shift_buffer_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic out_ready_r;
  logic ack_resp;
  logic stray_ack;
  logic tog;
  logic slow2;
  logic prev_rd;
  int   age;

  int total, bad;
  int wr_n, rd_n, ov_n, ol_n, done_n, ovl_n, outside_n, hold2, wr2, last_bad;
  int wr_log[$];

  shift_buffer_ctrl_if #(.ADDR_W(8)) sb_if ();

  assign sb_if.mem_ack   = ack_resp | stray_ack;
  assign sb_if.out_ready = out_ready_r;

  shift_buffer_ctrl #(.COLS(8), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SBC_ABORT_EN
    .abort (abort),
`endif
    .busy  (busy),
    .done  (done),
    .bus   (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack arrives one cycle into each request (five on addr 2 when slow2).
  always @(posedge clk) begin
    #2;
    if (tog) out_ready_r = ~out_ready_r;
    if (sb_if.mem_rd_en && (ack_resp || !prev_rd)) age = 0;
    else if (sb_if.mem_rd_en) age++;
    prev_rd  = sb_if.mem_rd_en;
    ack_resp = sb_if.mem_rd_en && (age == ((slow2 && sb_if.mem_addr == 8'd2) ? 5 : 1));
  end

  always @(negedge clk) begin
    if (sb_if.sb_write_en) begin
      wr_n++;
      wr_log.push_back(int'(sb_if.mem_addr));
      if (sb_if.mem_addr == 8'd2) wr2++;
    end
    if (sb_if.sb_read_en) rd_n++;
    if (sb_if.out_valid) ov_n++;
    if (sb_if.out_last) begin
      ol_n++;
      if (!sb_if.out_valid || (ov_n % 16) != 0) last_bad++;
    end
    if (done) done_n++;
    if (sb_if.sb_read_en && sb_if.sb_write_en) ovl_n++;
    if ((sb_if.sb_read_en || sb_if.sb_write_en) && !busy) outside_n++;
    if (sb_if.mem_rd_en && sb_if.mem_addr == 8'd2) hold2++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    wr_n = 0; rd_n = 0; ov_n = 0; ol_n = 0; done_n = 0;
    ovl_n = 0; outside_n = 0; hold2 = 0; wr2 = 0; last_bad = 0;
    wr_log.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 3000 && done_n < n; i++) tick();
    chk("done_reached", done_n, n);
  endtask

  function automatic int log_err(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= wr_log.size()) e++;
      else if (wr_log[i] != i) e++;
    end
    return e;
  endfunction

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    out_ready_r = 1'b1; ack_resp = 1'b0; stray_ack = 1'b0;
    tog = 1'b0; slow2 = 1'b0; prev_rd = 1'b0; age = 0;
    clr();

    // Reset state
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mem", int'({sb_if.mem_rd_en, sb_if.mem_addr}), 0);
    chk("rst_strobes", int'({sb_if.sb_write_en, sb_if.sb_read_en}), 0);
    chk("rst_out", int'({sb_if.out_valid, sb_if.out_last}), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) tick();
    chk("idle_wait_busy", int'(busy), 0);
    chk("idle_wait_writes", wr_n, 0);

    // Full pass, ack one cycle after request, out_ready always high
    clr();
    pulse_start();
    wait_done(1);
    repeat (3) tick();
    chk("p1_writes", wr_n, 8);
    chk("p1_addr_seq", log_err(8), 0);
    chk("p1_reads", rd_n, 80);
    chk("p1_valid", ov_n, 80);
    chk("p1_last", ol_n, 5);
    chk("p1_last_pos", last_bad, 0);
    chk("p1_done", done_n, 1);
    chk("p1_overlap", ovl_n, 0);
    chk("p1_outside", outside_n, 0);
    chk("p1_hold2", hold2, 2);
    chk("p1_busy_end", int'(busy), 0);

    // out_ready toggling every cycle
    clr();
    tog = 1'b1;
    pulse_start();
    wait_done(1);
    tog = 1'b0;
    out_ready_r = 1'b1;
    repeat (3) tick();
    chk("tog_valid", ov_n, 80);
    chk("tog_reads", rd_n, 80);
    chk("tog_last", ol_n, 5);
    chk("tog_last_pos", last_bad, 0);
    chk("tog_overlap", ovl_n, 0);
    chk("tog_writes", wr_n, 8);

    // Slow ack on addr 2
    clr();
    slow2 = 1'b1;
    pulse_start();
    wait_done(1);
    slow2 = 1'b0;
    repeat (3) tick();
    chk("slow_hold2", hold2, 6);
    chk("slow_wr2", wr2, 1);
    chk("slow_writes", wr_n, 8);
    chk("slow_addr_seq", log_err(8), 0);

    // Stray ack in READ, then reset mid-window 2
    clr();
    pulse_start();
    for (int i = 0; i < 500 && ov_n < 20; i++) tick();
    chk("w2_reached", ov_n, 20);
    @(posedge clk);
    #2 stray_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2 stray_ack = 1'b0;
    tick();
    chk("stray_ack_writes", wr_n, 5);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_mem", int'({sb_if.mem_rd_en, sb_if.mem_addr}), 0);
    chk("mid_rst_strobes", int'({sb_if.sb_write_en, sb_if.sb_read_en}), 0);
    chk("mid_rst_out", int'({sb_if.out_valid, sb_if.out_last, done}), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", int'(busy), 0);
    clr();
    pulse_start();
    wait_done(1);
    repeat (2) tick();
    chk("restart_addr_seq", log_err(8), 0);
    chk("restart_valid", ov_n, 80);

    // start held high across done
    clr();
    @(posedge clk);
    #2 start = 1'b1;
    wait_done(1);
    chk("held_writes_p1", wr_n, 8);
    chk("held_addr_p1", log_err(8), 0);
    chk("held_busy_in_done", int'(busy), 1);
    tick();
    chk("held_idle_gap", int'(busy), 0);
    tick();
    chk("held_restart", int'(busy), 1);
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(2);
    repeat (3) tick();
    chk("held_writes_total", wr_n, 16);
    chk("held_valid_total", ov_n, 160);
    chk("held_busy_end", int'(busy), 0);

`ifdef SBC_ABORT_EN
    // Abort during fetch of column 5
    clr();
    pulse_start();
    for (int i = 0; i < 500 && !(sb_if.mem_rd_en && sb_if.mem_addr == 8'd5); i++) tick();
    chk("abort_at_col5", int'(sb_if.mem_addr), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    repeat (40) tick();
    chk("abort_no_done", done_n, 0);
    chk("abort_writes", wr_n, 5);
    chk("abort_busy_end", int'(busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
